// File: rtl/if_axi_responder.sv
// if_axi_responder
//
// Responder end of the instruction-fetch request interface. Fetch requests
// (op=0) become single-beat 64-bit AXI4 reads. Write requests (op=1) are illegal
// on the fetch port, so they complete locally with zero data. Responses return
// in strict request order: a small order FIFO records the kind of each accepted
// request, and the response side always serves the FIFO head.
//
// Parameters
//   MAX_OUTSTANDING  accepted-but-uncompleted requests (legal 1..4)
//   AXI_ID           constant ARID
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   if_req_valid/if_req_op   IF request valid / 0=fetch, 1=write (local)
//   inst_addr                byte address of the request
//   inst_addr_ok             request accepted this cycle
//   inst_data_ok             response valid this cycle (always consumed)
//   inst_data, inst_err      response data / AXI error, qualified by inst_data_ok
//   ar_*                     AXI read-address channel (single beat, 8 bytes, INCR)
//   r_*                      AXI read-data channel (r_last, r_id ignored)
module if_axi_responder #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  // IF-stage request/response
  input  logic        if_req_valid,
  input  logic        if_req_op,
  input  logic [63:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [63:0] inst_data,
  output logic        inst_err,
  // AXI read-address channel
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [3:0]  ar_id,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  // AXI read-data channel
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [63:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic [3:0]  r_id
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    KindAxi   = 1'b0,
    KindLocal = 1'b1
  } kind_e;

  // Order FIFO state
  kind_e           kind_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // AR holding register
  logic            ar_valid_q, ar_valid_d;
  logic [63:0]     ar_addr_q, ar_addr_d;

  logic            not_full;
  logic            not_empty;
  logic            head_local;
  logic            push;
  logic            pop;

  // r_last, r_id and the byte offset are intentionally not used.
  logic unused_ok;
  assign unused_ok = ^{r_last, r_id, inst_addr[2:0]};

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // Uses only registered state plus the request inputs, so there is no
  // combinational path from r_valid or ar_ready to inst_addr_ok. A pop in the
  // same cycle does not free a slot until the next cycle.
  assign not_full  = (count_q < MaxCnt);
  assign not_empty = (count_q != '0);

  // A fetch needs the AR holding register free; local writes do not.
  assign push = ~rst & if_req_valid & not_full & (if_req_op | ~ar_valid_q);

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  assign head_local = (kind_q[rd_ptr_q] == KindLocal);

  // LOCAL heads complete immediately; AXI heads wait for read data.
  assign pop = ~rst & not_empty & (head_local | r_valid);

  always_comb begin
    inst_addr_ok = push;
    inst_data_ok = pop;
    inst_data    = '0;
    inst_err     = 1'b0;
    r_ready      = ~rst & not_empty & ~head_local;
    if (pop && !head_local) begin
      inst_data = r_data;
      inst_err  = (r_resp != 2'b00);
    end
  end

  // ---------------------------------------------------------------------------
  // AXI read-address channel
  // ---------------------------------------------------------------------------
  assign ar_valid = ar_valid_q & ~rst;
  assign ar_addr  = ar_addr_q;
  assign ar_id    = AXI_ID;
  assign ar_len   = 8'd0;
  assign ar_size  = 3'b011;
  assign ar_burst = 2'b01;

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    if (ar_valid_q && ar_ready) begin
      ar_valid_d = 1'b0;
    end
    // A new fetch cannot coincide with a pending AR: push is gated by ~ar_valid.
    if (push && !if_req_op) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = {inst_addr[63:3], 3'b000};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer / count next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
    end
  end

  // Kind bits are reset too so the head kind is never X while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        kind_q[i] <= KindAxi;
      end
    end else if (push) begin
      kind_q[wr_ptr_q] <= if_req_op ? KindLocal : KindAxi;
    end
  end

endmodule

// File: tb/tb_if_axi_responder.sv
// Directed bench for if_axi_responder (MAX_OUTSTANDING=2). Expected responses
// are queued when a request is driven and compared whenever inst_data_ok fires.
module tb_if_axi_responder;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_op;
  logic [63:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_data;
  logic        inst_err;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  if_axi_responder #(
    .MAX_OUTSTANDING(2),
    .AXI_ID         (4'd0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_op    (if_req_op),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_data    (inst_data),
    .inst_err     (inst_err),
    .ar_valid     (ar_valid),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_id        (ar_id),
    .ar_len       (ar_len),
    .ar_size      (ar_size),
    .ar_burst     (ar_burst),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_resp       (r_resp),
    .r_last       (r_last),
    .r_id         (r_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the
  // falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: every response must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && inst_data_ok) begin
      chk("resp_pending", {63'b0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_data", inst_data, e.data);
        chk("resp_err", {63'b0, inst_err}, {63'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    if_req_valid = 1'b1;
    if_req_op = 1'b0;
    inst_addr = 64'h8000_0004;
    ar_ready = 1'b0;
    r_valid = 1'b1;
    r_data = 64'hFFFF;
    r_resp = 2'b00;
    r_last = 1'b1;
    r_id = 4'd0;
    tick();
    mid();
    chk("rst_addr_ok", {63'b0, inst_addr_ok}, 64'd0);
    chk("rst_data_ok", {63'b0, inst_data_ok}, 64'd0);
    chk("rst_data", inst_data, 64'd0);
    chk("rst_err", {63'b0, inst_err}, 64'd0);
    chk("rst_ar_valid", {63'b0, ar_valid}, 64'd0);
    chk("rst_r_ready", {63'b0, r_ready}, 64'd0);
    chk("rst_ar_addr", ar_addr, 64'd0);
    tick();
    rst = 1'b0;
    if_req_valid = 1'b0;
    r_valid = 1'b0;
    r_data = 64'd0;
    tick();

    // ---------------- single fetch ----------------
    if_req_valid = 1'b1;
    if_req_op = 1'b0;
    inst_addr = 64'h8000_0004;
    ar_ready = 1'b1;
    sb.push_back('{64'h1122_3344_5566_7788, 1'b0});
    mid();
    chk("single_addr_ok", {63'b0, inst_addr_ok}, 64'd1);
    chk("single_no_data_same_cycle", {63'b0, inst_data_ok}, 64'd0);
    tick();
    if_req_valid = 1'b0;
    mid();
    chk("single_ar_valid", {63'b0, ar_valid}, 64'd1);
    chk("single_ar_addr", ar_addr, 64'h8000_0000);
    chk("ar_id", {60'b0, ar_id}, 64'd0);
    chk("ar_len", {56'b0, ar_len}, 64'd0);
    chk("ar_size", {61'b0, ar_size}, 64'd3);
    chk("ar_burst", {62'b0, ar_burst}, 64'd1);
    chk("single_r_ready", {63'b0, r_ready}, 64'd1);
    chk("single_no_data_t1", {63'b0, inst_data_ok}, 64'd0);
    tick();
    r_valid = 1'b1;
    r_data = 64'h1122_3344_5566_7788;
    r_resp = 2'b00;
    mid();
    chk("single_data_ok_t2", {63'b0, inst_data_ok}, 64'd1);
    chk("single_ar_cleared", {63'b0, ar_valid}, 64'd0);
    tick();
    r_valid = 1'b0;
    mid();
    chk("idle_data_ok", {63'b0, inst_data_ok}, 64'd0);
    chk("idle_data_zero", inst_data, 64'd0);
    chk("idle_r_ready", {63'b0, r_ready}, 64'd0);

    // ---------------- full ----------------
    tick();
    if_req_valid = 1'b1;
    inst_addr = 64'h1000;
    sb.push_back('{64'hA1, 1'b0});
    mid();
    chk("full_acc1", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    inst_addr = 64'h2008;
    mid();
    chk("full_ar_gate", {63'b0, inst_addr_ok}, 64'd0);
    tick();
    sb.push_back('{64'hA2, 1'b0});
    mid();
    chk("full_acc2", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    inst_addr = 64'h3000;
    mid();
    chk("full_refuse1", {63'b0, inst_addr_ok}, 64'd0);
    tick();
    mid();
    chk("full_refuse2", {63'b0, inst_addr_ok}, 64'd0);
    tick();
    r_valid = 1'b1;
    r_data = 64'hA1;
    mid();
    chk("full_refuse_on_pop", {63'b0, inst_addr_ok}, 64'd0);
    chk("full_pop", {63'b0, inst_data_ok}, 64'd1);
    tick();
    r_valid = 1'b0;
    sb.push_back('{64'hA3, 1'b0});
    mid();
    chk("full_resume", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_valid = 1'b0;
    r_valid = 1'b1;
    r_data = 64'hA2;
    mid();
    tick();
    r_data = 64'hA3;
    mid();
    tick();
    r_valid = 1'b0;
    mid();
    chk("full_drained", {63'b0, r_ready}, 64'd0);

    // ---------------- ordering: fetch A, local B, fetch C ----------------
    tick();
    if_req_valid = 1'b1;
    if_req_op = 1'b0;
    inst_addr = 64'h4000;
    sb.push_back('{64'hAAAA, 1'b0});
    mid();
    chk("ord_a_acc", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_op = 1'b1;
    inst_addr = 64'h4100;
    sb.push_back('{64'h0, 1'b0});
    mid();
    chk("ord_b_acc", {63'b0, inst_addr_ok}, 64'd1);
    chk("ord_b_ar_valid", {63'b0, ar_valid}, 64'd1);
    tick();
    if_req_op = 1'b0;
    inst_addr = 64'h4200;
    r_valid = 1'b1;
    r_data = 64'hAAAA;
    mid();
    chk("ord_c_full", {63'b0, inst_addr_ok}, 64'd0);
    chk("ord_a_done", {63'b0, inst_data_ok}, 64'd1);
    tick();
    sb.push_back('{64'hCCCC, 1'b0});
    r_data = 64'hCCCC;
    mid();
    chk("ord_c_acc", {63'b0, inst_addr_ok}, 64'd1);
    chk("ord_b_r_ready", {63'b0, r_ready}, 64'd0);
    chk("ord_b_done", {63'b0, inst_data_ok}, 64'd1);
    tick();
    if_req_valid = 1'b0;
    mid();
    chk("ord_c_r_ready", {63'b0, r_ready}, 64'd1);
    tick();
    r_valid = 1'b0;
    mid();
    chk("ord_empty", {63'b0, inst_data_ok}, 64'd0);

    // ---------------- error response ----------------
    tick();
    if_req_valid = 1'b1;
    inst_addr = 64'h5000;
    sb.push_back('{64'hDEAD, 1'b1});
    mid();
    chk("err_acc", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_valid = 1'b0;
    mid();
    tick();
    r_valid = 1'b1;
    r_data = 64'hDEAD;
    r_resp = 2'b10;
    mid();
    chk("err_flag", {63'b0, inst_err}, 64'd1);
    tick();
    r_valid = 1'b0;
    r_resp = 2'b00;

    // ---------------- AR stall ----------------
    ar_ready = 1'b0;
    if_req_valid = 1'b1;
    inst_addr = 64'h6010;
    sb.push_back('{64'hD6, 1'b0});
    mid();
    chk("stall_acc", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    inst_addr = 64'h7000;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("stall_ar_valid", {63'b0, ar_valid}, 64'd1);
      chk("stall_ar_addr", ar_addr, 64'h6010);
      chk("stall_refuse", {63'b0, inst_addr_ok}, 64'd0);
      tick();
    end
    ar_ready = 1'b1;
    mid();
    chk("stall_hs_refuse", {63'b0, inst_addr_ok}, 64'd0);
    chk("stall_hs_ar_valid", {63'b0, ar_valid}, 64'd1);
    tick();
    sb.push_back('{64'hD7, 1'b0});
    mid();
    chk("stall_resume", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_valid = 1'b0;
    r_valid = 1'b1;
    r_data = 64'hD6;
    mid();
    tick();
    r_data = 64'hD7;
    mid();
    tick();
    r_valid = 1'b0;

    // ---------------- async reset mid-flight ----------------
    if_req_valid = 1'b1;
    if_req_op = 1'b0;
    inst_addr = 64'h9000;
    mid();
    chk("rmf_acc1", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_op = 1'b1;
    mid();
    chk("rmf_acc2", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_op = 1'b0;
    inst_addr = 64'hA000;
    r_valid = 1'b1;
    r_data = 64'hBAD;
    #2;
    rst = 1'b1;
    #1;
    chk("rmf_addr_ok", {63'b0, inst_addr_ok}, 64'd0);
    chk("rmf_data_ok", {63'b0, inst_data_ok}, 64'd0);
    chk("rmf_data", inst_data, 64'd0);
    chk("rmf_err", {63'b0, inst_err}, 64'd0);
    chk("rmf_ar_valid", {63'b0, ar_valid}, 64'd0);
    chk("rmf_r_ready", {63'b0, r_ready}, 64'd0);
    chk("rmf_ar_addr", ar_addr, 64'd0);
    tick();
    rst = 1'b0;
    if_req_valid = 1'b0;
    mid();
    // Stray r_valid with an empty FIFO must not be consumed.
    chk("post_rst_data_ok", {63'b0, inst_data_ok}, 64'd0);
    chk("post_rst_r_ready", {63'b0, r_ready}, 64'd0);
    chk("post_rst_ar_valid", {63'b0, ar_valid}, 64'd0);
    tick();
    r_valid = 1'b0;
    if_req_valid = 1'b1;
    inst_addr = 64'hA000;
    sb.push_back('{64'hDA, 1'b0});
    mid();
    chk("post_rst_acc", {63'b0, inst_addr_ok}, 64'd1);
    tick();
    if_req_valid = 1'b0;
    mid();
    chk("post_rst_ar_addr", ar_addr, 64'hA000);
    tick();
    r_valid = 1'b1;
    r_data = 64'hDA;
    mid();
    tick();
    r_valid = 1'b0;
    mid();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_axi_responder.md
# if_axi_responder

Responder end of the instruction-fetch request interface (req_valid / op / addr → addr_ok, then data_ok / data). It accepts fetch requests from the IF stage, issues one single-beat AXI4 read per instruction-fetch request, and returns 64-bit data in strict request order. It sits between the IF stage and the AXI interconnect. Requests with op=1 are completed locally with zero data, because stores are illegal on the fetch port.

## Interface
- MAX_OUTSTANDING, 2: accepted-but-uncompleted requests, legal 1..4.
- AXI_ID, 4'd0: constant ARID value; RID is not checked.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  IF request valid.
- if_req_op  in  1  0 = fetch, 1 = write (illegal, completed locally).
- inst_addr  in  64  byte address of the request.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  response valid this cycle; the IF stage always consumes it.
- inst_data  out  64  response data, meaningful only when inst_data_ok=1.
- inst_err  out  1  AXI error on the returned response; qualified by inst_data_ok.
- ar_valid / ar_ready  out / in  1 each  AXI read-address handshake.
- ar_addr  out  64  {inst_addr[63:3], 3'b000}.
- ar_id  out  4  AXI_ID.
- ar_len  out  8  0.
- ar_size  out  3  3'b011.
- ar_burst  out  2  2'b01.
- r_valid / r_ready  in / out  1 each  AXI read-data handshake.
- r_data  in  64  read data.
- r_resp  in  2  read response.
- r_last  in  1  ignored; single beat.
- r_id  in  4  ignored.

## Operation
- Order FIFO: depth MAX_OUTSTANDING, one kind bit per entry (AXI or LOCAL), plus a count. It records accepted requests in order.
- AR holding register: ar_valid and ar_addr.
- Accept condition: inst_addr_ok = if_req_valid & (count < MAX_OUTSTANDING) & (if_req_op | ~ar_valid).
  - count is the registered value. A pop in the same cycle does not free a slot until the next cycle.
  - No combinational path from r_valid or ar_ready to inst_addr_ok.
- On accept with op=0:
  - Push AXI.
  - ar_valid<=1 and ar_addr<=aligned address at the next edge.
  - ar_valid holds with a stable ar_addr until ar_valid & ar_ready. It then clears unless a new op=0 accept occurs that same edge; a new accept is impossible because ~ar_valid gates it.
- On accept with op=1: push LOCAL. No AXI traffic.
- Response, taken from the FIFO head when count>0:
  - Head is LOCAL: inst_data_ok=1, inst_data=0, inst_err=0, pop.
  - Head is AXI: r_ready=1. When r_valid=1: inst_data_ok=1, inst_data=r_data, inst_err=(r_resp!=2'b00), pop.
  - r_ready=0 whenever the FIFO is empty or the head is LOCAL.
- Simultaneous push and pop: count is unchanged and both FIFO pointers advance.
- Full (count=MAX_OUTSTANDING): inst_addr_ok=0 regardless of if_req_valid.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- An r_valid that arrives while the FIFO is empty is a protocol violation. It is not consumed (r_ready=0).
- inst_data and inst_err are combinational from r_data/r_resp or the LOCAL constant. They are 0 when inst_data_ok=0.

## Timing
- Reset (async assert, sync release) clears count, the FIFO pointers, and ar_valid.
- Outputs while rst=1: inst_addr_ok, inst_data_ok, inst_data, inst_err, ar_valid and r_ready are all 0. ar_addr is 0.
- Reset mid-transaction drops all outstanding entries. The interconnect is reset together with this block.
- Fetch latency (accept at cycle T):
  - ar_valid rises at T+1.
  - With ar_ready=1 at T+1 and r_valid at T+2, inst_data_ok is at T+2.
  - Minimum is 2 cycles; every ar_ready or r_valid stall cycle adds 1.
- LOCAL latency: inst_data_ok at T+1 if the entry is at the head, otherwise 1 cycle after the prior entry pops.
- inst_data_ok is never asserted in the acceptance cycle of the same request. It may coincide with inst_addr_ok of a later request.
- Throughput: one fetch per cycle is not possible because of ~ar_valid gating. Back-to-back op=0 acceptances are at most every 2 cycles when ar_ready=1.

## Test plan
- Single fetch: reset, then if_req_valid=1, op=0, inst_addr=0x8000_0004 at T with ar_ready=1.
  - Expect inst_addr_ok at T; ar_valid with ar_addr=0x8000_0000 at T+1.
  - Drive r_valid, r_data=0x1122334455667788 at T+2: expect inst_data_ok=1, inst_data=0x1122334455667788, inst_err=0 at T+2.
- Full: MAX_OUTSTANDING=2, ar_ready=1, r_valid held 0, two fetches.
  - Expect inst_addr_ok=0 for the third request until the first r_valid.
  - inst_addr_ok returns 1 cycle after that pop.
- Ordering: sequence fetch A, op=1 B, fetch C; return C's r_valid early, while B is head.
  - Expect r_ready=0 until B completes with inst_data=0.
  - Responses complete in order A, B, C.
- Error: r_resp=2'b10 with r_data=0xDEAD → inst_data_ok=1, inst_err=1, inst_data=0xDEAD.
- AR stall: ar_ready=0 for 3 cycles.
  - ar_valid and ar_addr stay stable and a second fetch is refused.
  - Accept resumes the cycle after ar_ready=1.
- Async reset asserted mid-flight with count=2: all outputs 0 immediately; after release count=0 and the first new request is accepted.
